// File: rtl/multi_clock_divider.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Each channel emits a divided square wave and a one-cycle tick at period start.
// Divisor updates from the valid/ready port land glitch-free on a period boundary.
// Optional macro MCD_CASCADE_EN: channel i>0 advances only on tick[i-1].
module multi_clock_divider #(
  parameter  int unsigned CH          = 4,
  parameter  int unsigned W           = 16,
  parameter  int unsigned DEFAULT_DIV = 4,
  localparam int unsigned CW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] ch_en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  output logic [CH-1:0] pending,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [W-1:0] div_cl;

  // Divisors below 2 cannot form a square wave; store them as 2.
  assign div_cl = (cfg_div < W'(2)) ? W'(2) : cfg_div;

  // Ready unless the addressed channel still holds an unpromoted shadow.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(CH); i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = ~pending[i];
    end
  end

  for (genvar i = 0; i < int'(CH); i++) begin : g_ch
    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] act_q, act_d;
    logic [W-1:0] shd_q, shd_d;
    logic [W-1:0] div_use;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         acc;
    logic         adv;

    assign acc = cfg_valid && cfg_ready && (cfg_ch == CW'(i));

    if (i == 0) begin : g_free
      assign adv = 1'b1;
    end else begin : g_chain
`ifdef MCD_CASCADE_EN
      assign adv = tick[i-1];
`else
      assign adv = 1'b1;
`endif
    end

    // State and output registers; reset overrides any handshake.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        act_q   <= W'(DEFAULT_DIV);
        shd_q   <= '0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_q   <= act_d;
        shd_q   <= shd_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    // Next-state, counter, divisor promotion and next output values.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      div_use = act_q;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
          end
          if (acc) act_d = div_cl;
          if (ch_en[i]) begin
            state_d = ST_RUN;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (!ch_en[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (adv) begin
            if (cnt_q == act_q - W'(1)) begin
              cnt_d = '0;
              if (pend_q) begin
                act_d   = shd_q;
                pend_d  = 1'b0;
                div_use = shd_q;
              end
            end else begin
              cnt_d = cnt_q + W'(1);
            end
            clk_d  = (cnt_d < (div_use >> 1));
            tick_d = (cnt_d == '0);
          end else begin
            clk_d = clk_q;
          end
          // Shadow write; accept implies no pending, so a same-edge wrap used the old divisor.
          if (acc) begin
            shd_d  = div_cl;
            pend_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign pending[i] = pend_q;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider with hand-computed waveforms.
module tb_multi_clock_divider;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ch_en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic [CH-1:0] pending;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_clock_divider #(.CH(CH), .W(W), .DEFAULT_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .pending   (pending),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Count a comparison and report it if it misses.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift in n samples of one channel; first sample lands in the highest used bit.
  task automatic capture(input int ch, input int n, output logic [15:0] cp, output logic [15:0] tp);
    cp = '0;
    tp = '0;
    for (int k = 0; k < n; k++) begin
      step();
      cp = {cp[14:0], clk_out[ch]};
      tp = {tp[14:0], tick[ch]};
    end
  endtask

  initial begin
    logic [15:0] cp, tp;
    int          tk [3];
    int          nt;

    rst       = 1'b1;
    ch_en     = 4'b1111;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;

    // Reset defaults, then default divisor 4 on channel 0.
    step();
    step();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ready",   32'(cfg_ready), 32'h1);
    rst = 1'b0;
    capture(0, 8, cp, tp);
    check("d4_clk", 32'(cp), 32'h00CC);
    check("d4_tick", 32'(tp), 32'h0088);
    ch_en = 4'b0000;
    step();
    check("all_idle_clk", 32'(clk_out), 32'h0);

    // Odd divisor 5 written while idle: 2 high, 3 low.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 16'd5;
    #1;
    check("idle_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("idle_no_pending", 32'(pending), 32'h0);
    ch_en = 4'b0010;
    capture(1, 10, cp, tp);
    check("d5_clk", 32'(cp), 32'h0318);
    check("d5_tick", 32'(tp), 32'h0210);
    ch_en = 4'b0000;
    step();

    // Runtime change 4 -> 6 with backpressure on a second write.
    ch_en = 4'b0001;
    step();
    step();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 16'd6;
    #1;
    check("run_ready", 32'(cfg_ready), 32'h1);
    step();
    check("pend_set", 32'(pending[0]), 32'h1);
    check("old_d_cnt2_clk", 32'(clk_out[0]), 32'h0);
    cfg_div = 16'd7;
    #1;
    check("busy_ready", 32'(cfg_ready), 32'h0);
    step();
    check("pend_hold", 32'(pending[0]), 32'h1);
    check("busy_ready2", 32'(cfg_ready), 32'h0);
    check("old_d_cnt3_clk", 32'(clk_out[0]), 32'h0);
    step();
    cfg_valid = 1'b0;
    check("wrap_pend_clr", 32'(pending[0]), 32'h0);
    check("wrap_tick", 32'(tick[0]), 32'h1);
    check("wrap_clk", 32'(clk_out[0]), 32'h1);
    step();
    check("second_write_dropped", 32'(pending[0]), 32'h0);
    capture(0, 12, cp, tp);
    check("d6_clk", 32'(cp), 32'h08E3);
    check("d6_tick", 32'(tp), 32'h0082);
    ch_en = 4'b0000;
    step();

    // Clamp 0 -> 2, then disable and re-enable mid-run.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 16'd0;
    step();
    cfg_valid = 1'b0;
    ch_en = 4'b0100;
    capture(2, 5, cp, tp);
    check("d2_clk", 32'(cp), 32'h0015);
    check("d2_tick", 32'(tp), 32'h0015);
    ch_en = 4'b0000;
    step();
    check("dis_clk", 32'(clk_out[2]), 32'h0);
    check("dis_tick", 32'(tick[2]), 32'h0);
    ch_en = 4'b0100;
    step();
    check("reen_tick", 32'(tick[2]), 32'h1);

    // Reset while running with a pending shadow.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 16'd8;
    step();
    cfg_valid = 1'b0;
    check("pre_rst_pend", 32'(pending[2]), 32'h1);
    rst = 1'b1;
    step();
    check("mrst_clk", 32'(clk_out), 32'h0);
    check("mrst_tick", 32'(tick), 32'h0);
    check("mrst_pend", 32'(pending), 32'h0);
    rst = 1'b0;
    capture(2, 8, cp, tp);
    check("mrst_d4_clk", 32'(cp), 32'h00CC);
    check("mrst_d4_tick", 32'(tp), 32'h0088);
    ch_en = 4'b0000;
    step();

    // Channel 1 D=3 behind channel 0 D=4: tick[1] period.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 16'd3;
    step();
    cfg_valid = 1'b0;
    ch_en = 4'b0011;
    nt = 0;
    tk[0] = 0;
    tk[1] = 0;
    tk[2] = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tick[1] && nt < 3) begin
        tk[nt] = k;
        nt++;
      end
    end
`ifdef MCD_CASCADE_EN
    check("casc_period", 32'(tk[2] - tk[1]), 32'd12);
`else
    check("casc_period", 32'(tk[2] - tk[1]), 32'd3);
`endif
    ch_en = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
